// File: rtl/frame_row_scheduler_pkg.sv
// Shared types and queue marker words for the LCD row streaming path.
package LCDQueueTypes;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FRAME_HDR = 3'd1,
        ROW_HDR   = 3'd2,
        ROW_CMD   = 3'd3,
        ROW_DATA  = 3'd4,
        FRAME_TRL = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam int unsigned QUEUE_W = 17;
    localparam int unsigned PIXEL_W = 16;
    localparam int unsigned FREE_W  = 11;
    localparam int unsigned CNT_W   = 10;

    localparam logic [QUEUE_W-1:0] FRAME_START = 17'h10000;
    localparam logic [QUEUE_W-1:0] ROW_START   = 17'h10001;
    localparam logic [QUEUE_W-1:0] FRAME_END   = 17'h1FFFF;

endpackage

// File: rtl/frame_row_scheduler.sv
// Streams one frame of pixels from memory into the LCD queue, row by row,
// framing the data with start/row/end marker words.
module frame_row_scheduler
    import LCDQueueTypes::*;
#(
    parameter int unsigned FRAME_WIDTH  = 480,
    parameter int unsigned FRAME_HEIGHT = 272,
    parameter int unsigned ADDR_WIDTH   = 21
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_frame,
    input  logic [ADDR_WIDTH-1:0] frame_base_addr,
    output logic                  mem_cmd_valid,
    input  logic                  mem_cmd_ready,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    input  logic                  mem_rd_valid,
    input  logic [PIXEL_W-1:0]    mem_rd_data,
    input  logic [FREE_W-1:0]     queue_free,
    output logic                  queue_wr_en,
    output logic [QUEUE_W-1:0]    queue_data_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  overflow_err
);

    state_t                r_state,    w_state;
    logic                  r_busy,     w_busy;
    logic                  r_done,     w_done;
    logic                  r_cmd_vld,  w_cmd_vld;
    logic [ADDR_WIDTH-1:0] r_cmd_addr, w_cmd_addr;
    logic [ADDR_WIDTH-1:0] r_row_addr, w_row_addr;
    logic                  r_wr_en,    w_wr_en;
    logic [QUEUE_W-1:0]    r_data,     w_data;
    logic                  r_err,      w_err;
    logic [CNT_W-1:0]      r_row,      w_row;
    logic [CNT_W-1:0]      r_pix,      w_pix;

    logic w_row_space;
    logic w_last_pix;
    logic w_last_row;

    assign w_row_space = (queue_free >= FREE_W'(FRAME_WIDTH + 1));
    assign w_last_pix  = (r_pix == CNT_W'(FRAME_WIDTH - 1));
    assign w_last_row  = ((r_row + CNT_W'(1)) == CNT_W'(FRAME_HEIGHT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cmd_vld  <= 1'b0;
            r_cmd_addr <= '0;
            r_row_addr <= '0;
            r_wr_en    <= 1'b0;
            r_data     <= '0;
            r_err      <= 1'b0;
            r_row      <= '0;
            r_pix      <= '0;
        end else begin
            r_state    <= w_state;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_cmd_vld  <= w_cmd_vld;
            r_cmd_addr <= w_cmd_addr;
            r_row_addr <= w_row_addr;
            r_wr_en    <= w_wr_en;
            r_data     <= w_data;
            r_err      <= w_err;
            r_row      <= w_row;
            r_pix      <= w_pix;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_busy     = r_busy;
        w_done     = 1'b0;
        w_cmd_vld  = r_cmd_vld;
        w_cmd_addr = r_cmd_addr;
        w_row_addr = r_row_addr;
        w_wr_en    = 1'b0;
        w_data     = r_data;
        w_err      = r_err;
        w_row      = r_row;
        w_pix      = r_pix;

        // Read beats outside a row transfer have nowhere to go.
        if (mem_rd_valid && (r_state != ROW_DATA)) begin
            w_err = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (start_frame) begin
                    w_row_addr = frame_base_addr;
                    w_row      = '0;
                    w_pix      = '0;
                    w_busy     = 1'b1;
                    w_state    = FRAME_HDR;
                end
            end
            FRAME_HDR: begin
                if (queue_free != '0) begin
                    w_wr_en = 1'b1;
                    w_data  = FRAME_START;
                    w_state = ROW_HDR;
                end
            end
            ROW_HDR: begin
                // Reserve space for the header plus the whole unthrottled row.
                if (w_row_space) begin
                    w_wr_en    = 1'b1;
                    w_data     = ROW_START;
                    w_cmd_vld  = 1'b1;
                    w_cmd_addr = r_row_addr;
                    w_state    = ROW_CMD;
                end
            end
            ROW_CMD: begin
                if (r_cmd_vld && mem_cmd_ready) begin
                    w_cmd_vld = 1'b0;
                    w_state   = ROW_DATA;
                end
            end
            ROW_DATA: begin
                if (mem_rd_valid) begin
                    w_wr_en = 1'b1;
                    w_data  = {1'b0, mem_rd_data};
                    if (queue_free == '0) begin
                        w_err = 1'b1;
                    end
                    if (w_last_pix) begin
                        w_pix      = '0;
                        w_row      = r_row + CNT_W'(1);
                        w_row_addr = r_row_addr + ADDR_WIDTH'(FRAME_WIDTH);
                        w_state    = w_last_row ? FRAME_TRL : ROW_HDR;
                    end else begin
                        w_pix = r_pix + CNT_W'(1);
                    end
                end
            end
            FRAME_TRL: begin
                if (queue_free != '0) begin
                    w_wr_en = 1'b1;
                    w_data  = FRAME_END;
                    w_state = DONE;
                end
            end
            DONE: begin
                w_done  = 1'b1;
                w_busy  = 1'b0;
                w_state = IDLE;
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    assign mem_cmd_valid  = r_cmd_vld;
    assign mem_cmd_addr   = r_cmd_addr;
    assign queue_wr_en    = r_wr_en;
    assign queue_data_out = r_data;
    assign busy           = r_busy;
    assign frame_done     = r_done;
    assign overflow_err   = r_err;

endmodule

// File: tb/tb_frame_row_scheduler.sv
// Directed scoreboard bench for frame_row_scheduler with a small 4x2 frame.
module tb_frame_row_scheduler;
    import LCDQueueTypes::*;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned AW = 21;

    logic          clk;
    logic          reset;
    logic          start_frame;
    logic [AW-1:0] frame_base_addr;
    logic          mem_cmd_valid;
    logic          mem_cmd_ready;
    logic [AW-1:0] mem_cmd_addr;
    logic          mem_rd_valid;
    logic [15:0]   mem_rd_data;
    logic [10:0]   queue_free;
    logic          queue_wr_en;
    logic [16:0]   queue_data_out;
    logic          busy;
    logic          frame_done;
    logic          overflow_err;

    frame_row_scheduler #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_frame    (start_frame),
        .frame_base_addr(frame_base_addr),
        .mem_cmd_valid  (mem_cmd_valid),
        .mem_cmd_ready  (mem_cmd_ready),
        .mem_cmd_addr   (mem_cmd_addr),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_data    (mem_rd_data),
        .queue_free     (queue_free),
        .queue_wr_en    (queue_wr_en),
        .queue_data_out (queue_data_out),
        .busy           (busy),
        .frame_done     (frame_done),
        .overflow_err   (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int cmd_cnt  = 0;

    logic [16:0]   exp_q[$];
    logic [AW-1:0] exp_cmd[$];
    logic [AW-1:0] pending[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [15:0] pix(input logic [AW-1:0] a, input int i);
        logic [AW-1:0] s;
        s = a + AW'(i);
        return s[15:0] ^ 16'hC3A5;
    endfunction

    // Expected queue words and row command addresses for one whole frame.
    task automatic push_frame(input logic [AW-1:0] base);
        logic [AW-1:0] a;
        a = base;
        exp_q.push_back(FRAME_START);
        for (int r = 0; r < int'(H); r++) begin
            exp_cmd.push_back(a);
            exp_q.push_back(ROW_START);
            for (int i = 0; i < int'(W); i++) exp_q.push_back({1'b0, pix(a, i)});
            a = a + AW'(W);
        end
        exp_q.push_back(FRAME_END);
    endtask

    task automatic start(input logic [AW-1:0] base);
        @(posedge clk); #1;
        start_frame     = 1'b1;
        frame_base_addr = base;
        @(posedge clk); #1;
        start_frame     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int  d0;
        logic got;
        d0  = done_cnt;
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge clk);
            if (done_cnt > d0) got = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        repeat (3) @(posedge clk);
        chk({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_q_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_cmd_drained"}, 32'(exp_cmd.size()), 32'd0);
        @(negedge clk);
        chk({tag, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: pop expected words/commands as the DUT produces them.
    always @(negedge clk) begin
        if (!reset) begin
            if (queue_wr_en) begin
                if (exp_q.size() == 0) chk("q_unexpected", 32'(queue_data_out), 32'hFFFF_FFFF);
                else chk("q_word", 32'(queue_data_out), 32'(exp_q.pop_front()));
            end
            if (mem_cmd_valid && mem_cmd_ready) begin
                if (exp_cmd.size() == 0) chk("cmd_unexpected", 32'(mem_cmd_addr), 32'hFFFF_FFFF);
                else chk("cmd_addr", 32'(mem_cmd_addr), 32'(exp_cmd.pop_front()));
                cmd_cnt++;
                pending.push_back(mem_cmd_addr);
            end
            if (frame_done) done_cnt++;
        end
    end

    // Memory model: one row of back-to-back beats per accepted command.
    initial begin
        logic [AW-1:0] a;
        forever begin
            wait (pending.size() != 0);
            a = pending.pop_front();
            @(posedge clk); #1;
            for (int i = 0; i < int'(W); i++) begin
                if (reset) break;
                mem_rd_valid = 1'b1;
                mem_rd_data  = pix(a, i);
                @(posedge clk); #1;
            end
            mem_rd_valid = 1'b0;
        end
    end

    initial begin
        int c0;
        logic seen;
        reset           = 1'b1;
        start_frame     = 1'b0;
        frame_base_addr = '0;
        mem_cmd_ready   = 1'b1;
        mem_rd_valid    = 1'b0;
        mem_rd_data     = '0;
        queue_free      = 11'd1023;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(queue_wr_en), 32'd0);
        chk("rst_cmd_valid", 32'(mem_cmd_valid), 32'd0);
        chk("rst_data", 32'(queue_data_out), 32'd0);
        chk("rst_err", 32'(overflow_err), 32'd0);
        reset = 1'b0;

        // Basic frame: base 0x100, rows at 0x100 and 0x104.
        push_frame(21'h100);
        start(21'h100);
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_done("basic", 200);
        chk("data_hold", 32'(queue_data_out), 32'h1FFFF);
        chk("basic_no_err", 32'(overflow_err), 32'd0);

        // Row header withheld while queue space is short of a full row.
        queue_free = 11'd4;
        push_frame(21'h40);
        start(21'h40);
        @(negedge clk);
        @(negedge clk);
        chk("hdr_written", 32'(queue_wr_en), 32'd1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("space_hold_wr", 32'(queue_wr_en), 32'd0);
            chk("space_hold_cmd", 32'(mem_cmd_valid), 32'd0);
        end
        queue_free = 11'd5;
        @(negedge clk);
        chk("space_row_wr", 32'(queue_wr_en), 32'd1);
        chk("space_row_word", 32'(queue_data_out), 32'(ROW_START));
        queue_free = 11'd1023;
        wait_done("space", 200);

        // Command backpressure: valid held with stable address.
        mem_cmd_ready = 1'b0;
        push_frame(21'h80);
        start(21'h80);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_cmd_valid) seen = 1'b1;
        end
        chk("bp_valid_seen", 32'(seen), 32'd1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", 32'(mem_cmd_valid), 32'd1);
            chk("bp_addr_hold", 32'(mem_cmd_addr), 32'h80);
        end
        @(posedge clk); #1;
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_accept_once", 32'(mem_cmd_valid), 32'd0);
        wait_done("bp", 200);

        // Reset in the middle of row 1 data.
        push_frame(21'h200);
        c0 = cmd_cnt;
        start(21'h200);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(posedge clk);
            if (cmd_cnt >= c0 + 2) seen = 1'b1;
        end
        chk("mid_row1_reached", 32'(seen), 32'd1);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wr", 32'(queue_wr_en), 32'd0);
        chk("mid_rst_data", 32'(queue_data_out), 32'd0);
        chk("mid_rst_cmd", 32'(mem_cmd_valid), 32'd0);
        chk("mid_rst_addr", 32'(mem_cmd_addr), 32'd0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(IDLE));
        exp_q.delete();
        exp_cmd.delete();
        pending.delete();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        push_frame(21'h300);
        start(21'h300);
        wait_done("after_rst", 200);

        // Stray read beat while idle: dropped, sticky error.
        @(posedge clk); #1;
        mem_rd_valid = 1'b1;
        mem_rd_data  = 16'hBEEF;
        @(posedge clk); #1;
        mem_rd_valid = 1'b0;
        @(negedge clk);
        chk("stray_no_write", 32'(queue_wr_en), 32'd0);
        chk("stray_err", 32'(overflow_err), 32'd1);
        push_frame(21'h10);
        start(21'h10);
        wait_done("sticky", 200);
        chk("err_sticky", 32'(overflow_err), 32'd1);

        // Address wrap at the top of the address space.
        push_frame(21'h1FFFFE);
        start(21'h1FFFFE);
        wait_done("wrap", 200);
        chk("wrap_last_addr", 32'(mem_cmd_addr), 32'h000002);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_row_scheduler.md
FRAME_ROW_SCHEDULER -- requirements
Module: frame_row_scheduler

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 480, pixels per row (1..1023).
REQ-002 SHALL have parameter FRAME_HEIGHT, default 272, rows per frame (1..1023).
REQ-003 SHALL have parameter ADDR_WIDTH, default 21, memory word-address width.
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- start_frame  in  1  one-cycle request to stream one frame.
- frame_base_addr  in  ADDR_WIDTH  frame start address; sampled when start_frame is accepted.
- mem_cmd_valid  out  1  row read command valid.
- mem_cmd_ready  in  1  memory accepts command.
- mem_cmd_addr  out  ADDR_WIDTH  row start address.
- mem_rd_valid  in  1  read data beat valid; no backpressure.
- mem_rd_data  in  16  RGB565 pixel.
- queue_free  in  11  free words in the LCD queue.
- queue_wr_en  out  1  queue write strobe.
- queue_data_out  out  17  queue word.
- busy  out  1  high from start acceptance until frame_done.
- frame_done  out  1  one-cycle pulse after the end marker is written.
- overflow_err  out  1  sticky error flag.

Function
REQ-010 Queue word format SHALL be: pixel = {1'b0, rgb565}; FRAME_START = 17'h10000; ROW_START = 17'h10001; FRAME_END = 17'h1FFFF.
REQ-011 States SHALL be IDLE, FRAME_HDR, ROW_HDR, ROW_CMD, ROW_DATA, FRAME_TRL, DONE.
REQ-012 IDLE: start_frame=1 SHALL latch frame_base_addr, clear the row counter, set busy, and go to FRAME_HDR. start_frame SHALL be ignored in all other states.
REQ-013 FRAME_HDR: when queue_free != 0, SHALL write FRAME_START for one cycle and go to ROW_HDR. Otherwise SHALL hold with queue_wr_en=0.
REQ-014 ROW_HDR: SHALL wait until queue_free >= FRAME_WIDTH+1, then write ROW_START and go to ROW_CMD. Checking space for the full row before the header guarantees room for the unthrottled data.
REQ-015 ROW_CMD: SHALL drive mem_cmd_valid=1 with mem_cmd_addr = base + row*FRAME_WIDTH (mod 2^ADDR_WIDTH). Command SHALL complete on the cycle where mem_cmd_valid and mem_cmd_ready are both 1, then go to ROW_DATA. valid SHALL stay high and addr stable until accepted.
REQ-016 ROW_DATA: each mem_rd_valid beat SHALL produce queue_wr_en=1 and queue_data_out={1'b0,mem_rd_data} on the next cycle (latency 1) and increment the pixel counter.
REQ-017 After beat FRAME_WIDTH, SHALL clear the pixel counter and increment row. If the new row == FRAME_HEIGHT, SHALL go to FRAME_TRL, else to ROW_HDR.
REQ-018 FRAME_TRL: when queue_free != 0, SHALL write FRAME_END, then go to DONE.
REQ-019 DONE: SHALL pulse frame_done for one cycle, clear busy, and return to IDLE. A start_frame in the DONE cycle SHALL be ignored.
REQ-020 A mem_rd_valid while not in ROW_DATA SHALL be dropped and SHALL set overflow_err. A beat arriving when queue_free==0 SHALL still be written and SHALL set overflow_err.
REQ-021 overflow_err SHALL clear only on reset.
REQ-022 queue_wr_en SHALL be high at most one word per cycle. queue_data_out SHALL hold its last value when queue_wr_en=0.

Reset
REQ-030 Asserting reset SHALL, immediately and in any state, force state=IDLE and clear busy, frame_done, mem_cmd_valid, queue_wr_en, overflow_err, all counters, mem_cmd_addr, and queue_data_out (all =0).
REQ-031 Reset mid-frame SHALL NOT emit a FRAME_END marker. The next frame restarts from row 0.

Structure
REQ-040 Package LCDQueueTypes SHALL hold the state enum and the three marker constants. LCD_Controller SHALL import the same package.
REQ-041 Row address SHALL be kept as a running accumulator (+FRAME_WIDTH per row), with no multiplier. No sub-modules.

Verification
REQ-050 W=4, H=2, base=0x100, mem_cmd_ready=1, queue_free=1023. One start_frame -> queue sequence 10000,10001,px0..3,10001,px4..7,1FFFF. Cmd addrs 0x100 then 0x104. frame_done pulses once.
REQ-051 Hold queue_free=4 (< W+1=5) after FRAME_HDR -> ROW_START and the command are withheld. Raising queue_free to 5 -> ROW_START is written next cycle.
REQ-052 mem_cmd_ready=0 for 10 cycles -> mem_cmd_valid stays 1 with a stable addr. The command completes on the first ready=1 cycle.
REQ-053 Assert reset during row 1 data -> all outputs 0 and state IDLE. A new start_frame streams a full frame beginning at FRAME_START.
REQ-054 Inject mem_rd_valid in IDLE -> no queue write; overflow_err=1 and it stays 1 across a complete subsequent frame.
REQ-055 base=2^21-2, W=4 -> second row addr wraps to 0x000002.
